mux16_rr_arbiter: RTL

//  Round-robin arbiter and sequencer for the 16:1 x 8-bit byte multiplexer.
//  - 16 requesters share one downstream byte sink; block picks a winner, drives mux sel[3:0].
//  - Presents mux output to sink with a valid/ready handshake; acks the winner on transfer.
//  - Sits between requester front-ends and the multiplexer16to1 select input.

---
 rtl/mux16_rr_arbiter.sv | 124 ++++++++++++
 1 files changed

// File: rtl/mux16_rr_arbiter.sv
// ============================================================================
// Module      : mux16_rr_arbiter
// Description : Round-robin arbiter/sequencer driving the select of a 16:1
//               byte mux, with a valid/ready handshake toward the sink.
//               Optional back-to-back bursts enabled by macro ARB_BURST_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mux16_rr_arbiter #(
    parameter int NREQ      = 16,
    parameter int MAX_BURST = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NREQ-1:0]          req,
    output logic [NREQ-1:0]          ack,
    output logic [$clog2(NREQ)-1:0]  sel,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     busy
);

    localparam int SEL_W = $clog2(NREQ);

`ifdef ARB_BURST_EN
    localparam bit BURST_EN = 1'b1;
`else
    localparam bit BURST_EN = 1'b0;
`endif

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic [SEL_W-1:0]   ptr_q, ptr_d;
    logic               out_valid_q, out_valid_d;
    logic [3:0]         beat_cnt_q, beat_cnt_d;

    logic [SEL_W-1:0]   w_winner;
    logic               w_found;
    logic               w_accept;
    logic               w_burst_more;

    // Rotating priority search starting at ptr
    always_comb begin
        w_winner = '0;
        w_found  = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (!w_found && req[ptr_q + SEL_W'(i)]) begin
                w_winner = ptr_q + SEL_W'(i);
                w_found  = 1'b1;
            end
        end
    end

    assign w_accept     = (state_q == ST_GRANT) && out_valid_q && out_ready;
    // Constant-folds to 0 when bursts are compiled out
    assign w_burst_more = BURST_EN && req[sel_q] &&
                          (({1'b0, beat_cnt_q} + 5'd1) < 5'(MAX_BURST));

    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        ptr_d       = ptr_q;
        out_valid_d = out_valid_q;
        beat_cnt_d  = beat_cnt_q;
        ack         = '0;
        case (state_q)
            ST_IDLE: begin
                if (w_found) begin
                    sel_d       = w_winner;
                    out_valid_d = 1'b1;
                    beat_cnt_d  = 4'd0;
                    state_d     = ST_GRANT;
                end
            end
            ST_GRANT: begin
                if (w_accept) begin
                    ack[sel_q] = 1'b1;
                    if (w_burst_more) begin
                        beat_cnt_d = beat_cnt_q + 4'd1;
                    end else begin
                        ptr_d       = sel_q + SEL_W'(1);
                        out_valid_d = 1'b0;
                        beat_cnt_d  = 4'd0;
                        state_d     = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d     = ST_IDLE;
                out_valid_d = 1'b0;
                beat_cnt_d  = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            sel_q       <= '0;
            ptr_q       <= '0;
            out_valid_q <= 1'b0;
            beat_cnt_q  <= 4'd0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            ptr_q       <= ptr_d;
            out_valid_q <= out_valid_d;
            beat_cnt_q  <= beat_cnt_d;
        end
    end

    assign sel       = sel_q;
    assign out_valid = out_valid_q;
    assign busy      = (state_q == ST_GRANT);

endmodule

`default_nettype wire
